bm_iter_rt: RTL and testbench
=============================

// Module: bm_iter_rt
// PURPOSE
//  Runtime-configurable inversionless Berlekamp-Massey engine for the decryption path. It reads 2*t_run
//  syndromes from synd_gen RAM (1-cycle read latency) and produces the error-locator polynomial for the Chien/root stage.
//  t_run is selected per decode via t_sel, up to T_MAX. A chunked datapath of N GF multipliers trades area for latency.
//  Adds synchronous reset, busy, degree output and a decode-failure flag.
// PARAMETERS
//  m        13        GF(2^m) field width
//  GF_POLY  13'h001B  reduction polynomial without the x^m term (x^13+x^4+x^3+x+1)
//  T_MAX    119       maximum correctable errors; sigma storage is T_MAX+1 coefficients
//  N        10        GF multipliers per chunk; C = ceil((T_MAX+1)/N)
// PORTS
//  clk            in   1                  clock, all logic on posedge
//  rst_n          in   1                  synchronous, active-low reset
//  start          in   1                  1-cycle pulse, begin decode (ignored while busy)
//  t_sel          in   CLOG2(T_MAX+1)     t_run for this decode, sampled at start
//  synd_dout      in   m                  syndrome RAM data, valid 1 cycle after synd_rd_en
//  synd_rd_en     out  1                  syndrome RAM read enable
//  synd_rd_addr   out  CLOG2(2*T_MAX)     address; addr j holds S_(j+1)
//  error_loc_poly out  m*(T_MAX+1)        slice [m*i +: m] = sigma_i (coeff of x^i), unnormalised
//  deg            out  CLOG2(2*T_MAX+1)   final L (register length)
//  fail           out  1                  L > t_run at completion
//  busy           out  1                  high from cycle after start until done cycle inclusive
//  done           out  1                  1-cycle pulse; outputs valid and held until next start
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE, every output 0, internal sigma/B/S cleared. Applies mid-operation; the decode is abandoned with no done.
//  - t_sel of 0 or > T_MAX is taken as T_MAX.
//  - On accepted start: clear outputs, sigma=1, B=1, L=0, delta=1, k=0.
//  - IDLE -> LOAD on start.
//  - LOAD: synd_rd_en high for 2*t_run cycles, addr 0..2*t_run-1. Capture one cycle later into S[1..2*t_run].
//    One drain cycle, then -> DCALC. S indices outside 1..2*t_run read as 0.
//  - DCALC (C cycles): d = XOR over i of sigma_i*S_(k+1-i), N coefficients per cycle, low chunk first. -> UPDATE.
//  - UPDATE (C cycles), chunked: sigma' = delta*sigma ^ d*x*B.
//    If d!=0 and 2L<=k: B'=old sigma. Otherwise B'=x*B.
//    The carry coefficient crosses chunks; coefficients beyond x^T_MAX are dropped.
//  - BOOK (1 cycle): if d!=0 and 2L<=k, L=k+1-L and delta=d. k=k+1.
//    If k==2*t_run-1 before increment -> DONE, else -> DCALC.
//  - DONE (1 cycle): done=1, error_loc_poly=sigma, deg=L, fail=(L>t_run). -> IDLE.
//  - Latency: done asserts exactly 2*t_run + 2 + 2*t_run*(2C+1) cycles after the start cycle.
//  - start while busy: ignored, no effect on state or t_run. start on the done cycle: ignored; accepted from the next cycle.
//  - GF multiply: bit-serial-free combinational shift-and-reduce with GF_POLY, m-bit result. L and k are unsigned integers.
//  - Outputs change only on an accepted start (cleared), in DONE (loaded), or on reset.
// TESTING (bench params: m=4, GF_POLY=4'h3, T_MAX=2, N=1, so C=3)
//  1 Reset: hold rst_n=0 3 cycles, release -> all outputs 0, busy=0. Assert rst_n=0 mid-DCALC -> IDLE next cycle, no done.
//  2 Single error: t_sel=2, S1..S4=4'h8,4'hC,4'hA,4'hF -> done at cycle 34, error_loc_poly=12'h0FA, deg=1, fail=0.
//  3 All-zero syndromes: t_sel=2 -> done at cycle 34, error_loc_poly=12'h001, deg=0, fail=0.
//  4 Overflow: t_sel=1, S1=0, S2=1 -> reads addr 0,1 only, done at cycle 18, error_loc_poly=12'h101, deg=2, fail=1.
//  5 start pulses while busy (LOAD and UPDATE) -> ignored, result identical to scenario 2. Back-to-back decode starting the cycle after done -> correct.
//  6 t_sel=0 and t_sel=3 -> treated as t_run=2: 4 syndrome reads, done at cycle 34.

Source files
------------

// File: rtl/bm_iter_rt.sv
// Inversionless Berlekamp-Massey engine with runtime-selectable t.
// Loads 2*t_run syndromes from a 1-cycle-latency RAM, then runs 2*t_run
// iterations of (DCALC, UPDATE, BOOK) over a chunked datapath of N
// coefficients per cycle, and presents the unnormalised error-locator.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, t_sel        decode request and its t (0 or > T_MAX means T_MAX)
//   synd_dout           syndrome RAM read data (valid 1 cycle after read)
//   synd_rd_en/_addr    syndrome RAM read port, addr j holds S_(j+1)
//   error_loc_poly      sigma_i in slice [m*i +: m]
//   deg, fail           final L and (L > t_run)
//   busy, done          decode in progress / 1-cycle completion pulse
module bm_iter_rt #(
  parameter int unsigned  m       = 13,
  parameter logic [m-1:0] GF_POLY = 13'h001B,
  parameter int unsigned  T_MAX   = 119,
  parameter int unsigned  N       = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(T_MAX+1)-1:0]   t_sel,
  input  logic [m-1:0]                 synd_dout,
  output logic                         synd_rd_en,
  output logic [$clog2(2*T_MAX)-1:0]   synd_rd_addr,
  output logic [m*(T_MAX+1)-1:0]       error_loc_poly,
  output logic [$clog2(2*T_MAX+1)-1:0] deg,
  output logic                         fail,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned NC = T_MAX + 1;
  localparam int unsigned C  = (NC + N - 1) / N;
  localparam int unsigned TW = $clog2(T_MAX + 1);
  localparam int unsigned AW = $clog2(2 * T_MAX);
  localparam int unsigned DW = $clog2(2 * T_MAX + 1);
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned SN = 2 * T_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_DCALC, S_UPDATE, S_BOOK, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] t_run;
  logic [m-1:0]  sigma  [0:T_MAX];
  logic [m-1:0]  b_poly [0:T_MAX];
  logic [m-1:0]  synd   [0:SN-1];
  logic [m-1:0]  d, delta, carry;
  logic [DW-1:0] l_reg, k_reg;
  logic [CW-1:0] chunk;
  logic          rd_v;
  logic [AW-1:0] rd_a;

  logic              last_rd_c, last_chunk_c, last_iter_c, swap_c;
  logic [DW-1:0]     l_fin_c;
  logic [TW-1:0]     t_eff_c;
  logic [m-1:0]      d_part_c, carry_nxt_c, up_prev;
  logic [N*m-1:0]    upd_sig_c, upd_b_c;
  logic [NC*m-1:0]   poly_c;
  int                dc_idx, dc_sidx, up_idx;

  // Combinational GF(2^m) multiply: shift-and-reduce over the bits of b.
  function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
    logic [m-1:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < int'(m); i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[m-1] ? ((aa << 1) ^ GF_POLY) : (aa << 1);
    end
    return p;
  endfunction

  // Control decodes.
  assign t_eff_c      = ((t_sel == '0) || (t_sel > TW'(T_MAX))) ? TW'(T_MAX) : t_sel;
  assign last_rd_c    = ({1'b0, synd_rd_addr} == ((AW+1)'({t_run, 1'b0}) - (AW+1)'(1)));
  assign last_iter_c  = (k_reg == (DW'({t_run, 1'b0}) - DW'(1)));
  assign last_chunk_c = (chunk == CW'(C - 1));
  assign swap_c       = (d != '0) && ({l_reg, 1'b0} <= {1'b0, k_reg});
  assign l_fin_c      = swap_c ? (k_reg + DW'(1) - l_reg) : l_reg;

  // Discrepancy contribution of the current chunk; out-of-range S reads as 0.
  always_comb begin
    d_part_c = '0;
    dc_idx   = 0;
    dc_sidx  = 0;
    for (int j = 0; j < int'(N); j++) begin
      dc_idx  = int'(chunk) * int'(N) + j;
      dc_sidx = int'(k_reg) + 1 - dc_idx;
      if ((dc_idx <= int'(T_MAX)) && (dc_sidx >= 1) && (dc_sidx <= int'(SN)))
        d_part_c = d_part_c ^ gf_mul(sigma[TW'(dc_idx)], synd[AW'(dc_sidx - 1)]);
    end
  end

  // Chunk update; up_prev walks old B coefficients, seeded by the carry from the lower chunk.
  always_comb begin
    upd_sig_c = '0;
    upd_b_c   = '0;
    up_prev   = carry;
    up_idx    = 0;
    for (int j = 0; j < int'(N); j++) begin
      up_idx = int'(chunk) * int'(N) + j;
      if (up_idx <= int'(T_MAX)) begin
        upd_sig_c[j*m +: m] = gf_mul(delta, sigma[TW'(up_idx)]) ^ gf_mul(d, up_prev);
        upd_b_c[j*m +: m]   = swap_c ? sigma[TW'(up_idx)] : up_prev;
        up_prev             = b_poly[TW'(up_idx)];
      end
    end
    carry_nxt_c = up_prev;
  end

  // Flattened sigma for the result port.
  always_comb begin
    poly_c = '0;
    for (int i = 0; i < int'(NC); i++) poly_c[i*m +: m] = sigma[TW'(i)];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   if (last_rd_c) state_nxt = S_DRAIN;
      S_DRAIN:  state_nxt = S_DCALC;
      S_DCALC:  if (last_chunk_c) state_nxt = S_UPDATE;
      S_UPDATE: if (last_chunk_c) state_nxt = S_BOOK;
      S_BOOK:   state_nxt = last_iter_c ? S_DONE : S_DCALC;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_run          <= '0;
      d              <= '0;
      delta          <= '0;
      carry          <= '0;
      l_reg          <= '0;
      k_reg          <= '0;
      chunk          <= '0;
      rd_v           <= 1'b0;
      rd_a           <= '0;
      synd_rd_en     <= 1'b0;
      synd_rd_addr   <= '0;
      error_loc_poly <= '0;
      deg            <= '0;
      fail           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      for (int i = 0; i < int'(NC); i++) begin
        sigma[TW'(i)]  <= '0;
        b_poly[TW'(i)] <= '0;
      end
      for (int i = 0; i < int'(SN); i++) synd[AW'(i)] <= '0;
    end else begin
      // Read data returns one cycle after the request.
      rd_v <= synd_rd_en;
      rd_a <= synd_rd_addr;
      if (rd_v) synd[rd_a] <= synd_dout;
      case (state)
        S_IDLE: if (start) begin
          t_run <= t_eff_c;
          for (int i = 0; i < int'(NC); i++) begin
            sigma[TW'(i)]  <= '0;
            b_poly[TW'(i)] <= '0;
          end
          for (int i = 0; i < int'(SN); i++) synd[AW'(i)] <= '0;
          sigma[0]       <= m'(1);
          b_poly[0]      <= m'(1);
          delta          <= m'(1);
          d              <= '0;
          carry          <= '0;
          l_reg          <= '0;
          k_reg          <= '0;
          chunk          <= '0;
          synd_rd_en     <= 1'b1;
          synd_rd_addr   <= '0;
          error_loc_poly <= '0;
          deg            <= '0;
          fail           <= 1'b0;
          done           <= 1'b0;
          busy           <= 1'b1;
        end
        S_LOAD: begin
          if (last_rd_c) synd_rd_en   <= 1'b0;
          else           synd_rd_addr <= synd_rd_addr + AW'(1);
        end
        S_DCALC: begin
          d     <= (chunk == '0) ? d_part_c : (d ^ d_part_c);
          chunk <= last_chunk_c ? '0 : chunk + CW'(1);
          carry <= '0;
        end
        S_UPDATE: begin
          for (int j = 0; j < int'(N); j++) begin
            if (int'(chunk) * int'(N) + j <= int'(T_MAX)) begin
              sigma[TW'(int'(chunk) * int'(N) + j)]  <= upd_sig_c[j*m +: m];
              b_poly[TW'(int'(chunk) * int'(N) + j)] <= upd_b_c[j*m +: m];
            end
          end
          carry <= carry_nxt_c;
          chunk <= last_chunk_c ? '0 : chunk + CW'(1);
        end
        S_BOOK: begin
          l_reg <= l_fin_c;
          if (swap_c) delta <= d;
          k_reg <= k_reg + DW'(1);
          if (last_iter_c) begin
            error_loc_poly <= poly_c;
            deg            <= l_fin_c;
            fail           <= (l_fin_c > DW'(t_run));
            done           <= 1'b1;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bm_iter_rt.sv
// Bench for bm_iter_rt (m=4, x^4+x+1, T_MAX=2, N=1): directed scenarios plus
// random syndromes checked against a table-based Berlekamp-Massey model.
module tb_bm_iter_rt;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [1:0]  t_sel;
  logic [3:0]  synd_dout;
  logic        synd_rd_en;
  logic [1:0]  synd_rd_addr;
  logic [11:0] error_loc_poly;
  logic [2:0]  deg;
  logic        fail, busy, done;

  int checks = 0;
  int errors = 0;

  bm_iter_rt #(.m(4), .GF_POLY(4'h3), .T_MAX(2), .N(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .t_sel(t_sel),
    .synd_dout(synd_dout), .synd_rd_en(synd_rd_en), .synd_rd_addr(synd_rd_addr),
    .error_loc_poly(error_loc_poly), .deg(deg), .fail(fail), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Syndrome RAM with 1-cycle read latency, plus a read log.
  logic [3:0] mem [0:3];
  int n_reads = 0;
  int last_addr = -1;
  always @(posedge clk) begin
    if (synd_rd_en) begin
      synd_dout <= mem[synd_rd_addr];
      n_reads   <= n_reads + 1;
      last_addr <= int'(synd_rd_addr);
    end
  end

  // GF(16) via exp/log tables.
  logic [3:0] exp_tab [0:15];
  int         log_tab [0:15];

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return exp_tab[4'((log_tab[a] + log_tab[b]) % 15)];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference BM on whole polynomials (packed, coefficient i at [4i +: 4]).
  // sv holds S1..S4 at nibbles 0..3; only S1..S2t are used.
  task automatic bm_model(input int t, input logic [15:0] sv,
                          output logic [11:0] poly, output logic [2:0] lo, output logic fo);
    logic [11:0] sg, bb, ns;
    logic [3:0]  dd, dl;
    int          L, j;
    sg = 12'h001; bb = 12'h001; L = 0; dl = 4'h1;
    for (int k = 0; k < 2*t; k++) begin
      dd = 4'h0;
      for (int i = 0; i <= 2; i++) begin
        j = k + 1 - i;
        if (j >= 1 && j <= 2*t) dd = dd ^ gmul(sg[4*i +: 4], sv[4*(j-1) +: 4]);
      end
      ns = 12'h000;
      for (int i = 0; i <= 2; i++) begin
        ns[4*i +: 4] = gmul(dl, sg[4*i +: 4]);
        if (i > 0) ns[4*i +: 4] = ns[4*i +: 4] ^ gmul(dd, bb[4*(i-1) +: 4]);
      end
      if (dd != 4'h0 && 2*L <= k) begin
        bb = sg; L = k + 1 - L; dl = dd;
      end else begin
        bb = {bb[7:0], 4'h0};
      end
      sg = ns;
    end
    poly = sg; lo = 3'(L); fo = (L > t);
  endtask

  // One decode started at a negedge; ends at the negedge after the done cycle,
  // having also pulsed start on the done cycle (must be ignored).
  task automatic run(input logic [1:0] ts, input int te, input logic [15:0] sv,
                     input logic [11:0] ep, input logic [2:0] ed, input logic ef, input bit glitch);
    int cnt, base, lat;
    bit seen, busy_ok;
    for (int a = 0; a < 4; a++) mem[2'(a)] = sv[4*a +: 4];
    lat  = 2*te + 2 + 2*te*7;
    base = n_reads;
    start = 1'b1; t_sel = ts;
    cnt = 0; seen = 0; busy_ok = 1;
    while (!seen && cnt < 200) begin
      @(posedge clk); cnt++; @(negedge clk);
      start = 1'b0;
      if (glitch && (cnt == 2 || cnt == 10)) begin start = 1'b1; t_sel = 2'd1; end
      if (done) seen = 1;
      else if (!busy) busy_ok = 0;
    end
    chk("done_seen", 32'(seen), 32'(1));
    chk("latency", 32'(cnt), 32'(lat));
    chk("poly", 32'(error_loc_poly), 32'(ep));
    chk("deg", 32'(deg), 32'(ed));
    chk("fail", 32'(fail), 32'(ef));
    chk("busy_at_done", 32'(busy), 32'(1));
    chk("busy_during", 32'(busy_ok), 32'(1));
    chk("n_reads", 32'(n_reads - base), 32'(2*te));
    chk("last_addr", 32'(last_addr), 32'(2*te - 1));
    start = 1'b1; t_sel = ts;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'(0));
    chk("idle_after", 32'(busy), 32'(0));
    chk("poly_held", 32'(error_loc_poly), 32'(ep));
  endtask

  initial begin
    logic [3:0]  a;
    logic [11:0] ep;
    logic [2:0]  ed;
    logic        ef;
    logic [1:0]  ts;
    logic [15:0] sv;
    int          te;
    bit          seen;

    a = 4'h1;
    log_tab[0] = 0;
    exp_tab[15] = 4'h1;
    for (int i = 0; i < 15; i++) begin
      exp_tab[4'(i)] = a;
      log_tab[a] = i;
      a = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    end
    for (int i = 0; i < 4; i++) mem[2'(i)] = 4'h0;

    // Power-on reset.
    rst_n = 1'b0; start = 1'b0; t_sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_poly", 32'(error_loc_poly), 32'(0));
    chk("rst_deg", 32'(deg), 32'(0));
    chk("rst_fail", 32'(fail), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rd_en", 32'(synd_rd_en), 32'(0));

    // Single error, all-zero syndromes, overflow with t=1.
    run(2'd2, 2, 16'hFAC8, 12'h0FA, 3'd1, 1'b0, 1'b0);
    run(2'd2, 2, 16'h0000, 12'h001, 3'd0, 1'b0, 1'b0);
    run(2'd1, 1, 16'h5710, 12'h101, 3'd2, 1'b1, 1'b0);

    // Start pulses while busy, then back-to-back decodes with t_sel 0 and 3.
    run(2'd2, 2, 16'hFAC8, 12'h0FA, 3'd1, 1'b0, 1'b1);
    run(2'd0, 2, 16'hFAC8, 12'h0FA, 3'd1, 1'b0, 1'b0);
    run(2'd3, 2, 16'hFAC8, 12'h0FA, 3'd1, 1'b0, 1'b0);

    // Reset in the middle of DCALC abandons the decode.
    start = 1'b1; t_sel = 2'd2;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_rd_en", 32'(synd_rd_en), 32'(0));
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("midrst_quiet", 32'(seen), 32'(0));

    // Random syndromes against the model.
    for (int r = 0; r < 10; r++) begin
      ts = 2'($urandom_range(0, 3));
      te = (ts == 2'd0 || ts == 2'd3) ? 2 : int'(ts);
      sv = 16'($urandom);
      bm_model(te, sv, ep, ed, ef);
      run(ts, te, sv, ep, ed, ef, (r % 2) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
